// File: rtl/mips_pkg.sv
// Shared types for the MIPS memory unit: access sizes, FSM states and bus widths.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUS    = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } memu_state_t;

endpackage

// File: rtl/mips_lane_align.sv
// Little-endian lane steering: byteenable/writedata for stores, lane extract and extend for loads.
module mips_lane_align
  import mips_pkg::*;
(
  input  mem_size_t           size,
  input  logic [1:0]          addr_lo,
  input  logic                is_signed,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [BE_W-1:0]     byteenable,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   load_value,
  output logic                misaligned
);

  logic [DATA_W-1:0] shifted;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    byteenable = 4'b1111;
    writedata  = wdata;
    load_value = rdata;
    misaligned = 1'b0;

    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
        load_value = {{24{is_signed & lane_b[7]}}, lane_b};
      end
      SIZE_HALF: begin
        misaligned = addr_lo[0];
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
        load_value = {{16{is_signed & lane_h[15]}}, lane_h};
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mips_mem_unit.sv
// Single-outstanding Avalon-MM load/store master with waitrequest timeout and fixed read latency.
module mips_mem_unit
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  mem_size_t           req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_error,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [BE_W-1:0]     byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int unsigned TO_W  = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam int unsigned LAT_W = 2;

  memu_state_t       state;
  mem_size_t         size_q;
  logic [1:0]        addr_lo_q;
  logic              signed_q;
  logic [TO_W-1:0]   wait_cnt;
  logic [LAT_W-1:0]  lat_cnt;

  mem_size_t         al_size;
  logic [1:0]        al_addr_lo;
  logic              al_signed;
  logic [BE_W-1:0]   al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_load;
  logic              al_misaligned;
  logic              timeout_c;
  logic              lat_done_c;

  // In IDLE the aligner decodes the incoming request; afterwards it decodes the captured one.
  always_comb begin
    al_size    = (state == IDLE) ? req_size       : size_q;
    al_addr_lo = (state == IDLE) ? req_addr[1:0]  : addr_lo_q;
    al_signed  = (state == IDLE) ? req_signed     : signed_q;
    timeout_c  = (WAIT_TIMEOUT != 0) && (wait_cnt == TO_W'(WAIT_TIMEOUT - 1));
    lat_done_c = (lat_cnt == LAT_W'(RD_LATENCY - 1));
  end

  mips_lane_align u_align (
    .size       (al_size),
    .addr_lo    (al_addr_lo),
    .is_signed  (al_signed),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .byteenable (al_be),
    .writedata  (al_wdata),
    .load_value (al_load),
    .misaligned (al_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      size_q     <= SIZE_BYTE;
      addr_lo_q  <= 2'b00;
      signed_q   <= 1'b0;
      wait_cnt   <= '0;
      lat_cnt    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q    <= req_size;
            addr_lo_q <= req_addr[1:0];
            signed_q  <= req_signed;
            wait_cnt  <= '0;
            lat_cnt   <= '0;
            if (al_misaligned) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              address    <= {req_addr[ADDR_W-1:2], 2'b00};
              byteenable <= al_be;
              writedata  <= al_wdata;
              read       <= ~req_write;
              write      <= req_write;
              state      <= BUS;
              req_ready  <= 1'b0;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (write) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_rdata <= '0;
              state      <= IDLE;
              req_ready  <= 1'b1;
            end else begin
              state <= RDWAIT;
            end
          end else if (timeout_c) begin
            // Deliberate protocol abort: the slave never released waitrequest.
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= '0;
            state      <= IDLE;
            req_ready  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        RDWAIT: begin
          if (lat_done_c) begin
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= al_load;
            state      <= IDLE;
            req_ready  <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_unit.sv
// Directed bench: one unit at RD_LATENCY=1/WAIT_TIMEOUT=8, a second at RD_LATENCY=3 for reset abort.
module tb_mips_mem_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, reset_b;
  logic        req_valid_a, req_valid_b;
  logic        req_write, req_signed;
  mem_size_t   req_size;
  logic [31:0] req_addr, req_wdata;
  logic        waitrequest;
  logic [31:0] readdata;

  logic        req_ready_a, resp_valid_a, resp_error_a, read_a, write_a;
  logic [31:0] resp_rdata_a, address_a, writedata_a;
  logic [3:0]  byteenable_a;
  logic        req_ready_b, resp_valid_b, resp_error_b, read_b, write_b;
  logic [31:0] resp_rdata_b, address_b, writedata_b;
  logic [3:0]  byteenable_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_mem_unit #(.ADDR_W(32), .RD_LATENCY(1), .WAIT_TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_a),
    .resp_rdata(resp_rdata_a), .resp_error(resp_error_a), .address(address_a),
    .read(read_a), .write(write_a), .waitrequest(waitrequest),
    .writedata(writedata_a), .byteenable(byteenable_a), .readdata(readdata)
  );

  mips_mem_unit #(.ADDR_W(32), .RD_LATENCY(3), .WAIT_TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_b),
    .resp_rdata(resp_rdata_b), .resp_error(resp_error_b), .address(address_b),
    .read(read_b), .write(write_b), .waitrequest(waitrequest),
    .writedata(writedata_b), .byteenable(byteenable_b), .readdata(readdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input logic wr, input mem_size_t sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset_b = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    set_req(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
    waitrequest = 1'b0;
    readdata = 32'h0;
    step(); step();

    chk("rst_ready", 32'(req_ready_a), 32'h1);
    chk("rst_strobes", {30'h0, read_a, write_a}, 32'h0);
    chk("rst_be", 32'(byteenable_a), 32'h0);
    chk("rst_addr", address_a, 32'h0);
    chk("rst_resp", {30'h0, resp_valid_a, resp_error_a}, 32'h0);
    chk("rst_rdata", resp_rdata_a, 32'h0);
    reset = 1'b0; reset_b = 1'b0;

    // Word load, no waits: resp in cycle 3
    set_req(1'b0, SIZE_WORD, 1'b0, 32'hBFC00004, 32'h0);
    readdata = 32'h8C220010;
    req_valid_a = 1'b1;
    step(); req_valid_a = 1'b0;
    chk("wl_c1_read", 32'(read_a), 32'h1);
    chk("wl_c1_addr", address_a, 32'hBFC00004);
    chk("wl_c1_be", 32'(byteenable_a), 32'hF);
    chk("wl_c1_ready", 32'(req_ready_a), 32'h0);
    step();
    chk("wl_c2_read", 32'(read_a), 32'h0);
    chk("wl_c2_resp", 32'(resp_valid_a), 32'h0);
    step();
    chk("wl_c3_resp", 32'(resp_valid_a), 32'h1);
    chk("wl_c3_rdata", resp_rdata_a, 32'h8C220010);
    chk("wl_c3_err", 32'(resp_error_a), 32'h0);
    chk("wl_c3_ready", 32'(req_ready_a), 32'h1);
    step();
    chk("wl_c4_resp", 32'(resp_valid_a), 32'h0);
    chk("wl_hold_rdata", resp_rdata_a, 32'h8C220010);

    // Signed byte load, then back-to-back unsigned issued in the resp cycle
    set_req(1'b0, SIZE_BYTE, 1'b1, 32'h00001003, 32'h0);
    readdata = 32'h80FF0012;
    req_valid_a = 1'b1;
    step(); req_valid_a = 1'b0;
    chk("sb_be", 32'(byteenable_a), 32'h8);
    chk("sb_addr", address_a, 32'h00001000);
    step(); step();
    chk("sb_resp", 32'(resp_valid_a), 32'h1);
    chk("sb_rdata", resp_rdata_a, 32'hFFFFFF80);
    set_req(1'b0, SIZE_BYTE, 1'b0, 32'h00001003, 32'h0);
    req_valid_a = 1'b1;
    step(); req_valid_a = 1'b0;
    chk("ub_b2b_read", 32'(read_a), 32'h1);
    step(); step();
    chk("ub_resp", 32'(resp_valid_a), 32'h1);
    chk("ub_rdata", resp_rdata_a, 32'h00000080);

    // Signed half load from upper lanes
    set_req(1'b0, SIZE_HALF, 1'b1, 32'h00001002, 32'h0);
    req_valid_a = 1'b1;
    step(); req_valid_a = 1'b0;
    chk("sh_be", 32'(byteenable_a), 32'hC);
    step(); step();
    chk("sh_rdata", resp_rdata_a, 32'hFFFF80FF);

    // Half store with waitrequest high for 3 cycles
    set_req(1'b1, SIZE_HALF, 1'b0, 32'h00002002, 32'h1234ABCD);
    waitrequest = 1'b1;
    req_valid_a = 1'b1;
    step(); req_valid_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) waitrequest = 1'b0;
      chk($sformatf("hs_c%0d_write", i), {30'h0, read_a, write_a}, 32'h1);
      chk($sformatf("hs_c%0d_addr", i), address_a, 32'h00002000);
      chk($sformatf("hs_c%0d_be", i), 32'(byteenable_a), 32'hC);
      chk($sformatf("hs_c%0d_wdata", i), writedata_a, 32'hABCDABCD);
      chk($sformatf("hs_c%0d_resp", i), 32'(resp_valid_a), 32'h0);
      step();
    end
    chk("hs_c5_write", 32'(write_a), 32'h0);
    chk("hs_c5_resp", 32'(resp_valid_a), 32'h1);
    chk("hs_c5_err", 32'(resp_error_a), 32'h0);
    chk("hs_c5_rdata", resp_rdata_a, 32'h0);

    // Byte store, no waits: resp in cycle 2
    set_req(1'b1, SIZE_BYTE, 1'b0, 32'h00005001, 32'h000000A5);
    req_valid_a = 1'b1;
    step(); req_valid_a = 1'b0;
    chk("bs_be", 32'(byteenable_a), 32'h2);
    chk("bs_wdata", writedata_a, 32'hA5A5A5A5);
    step();
    chk("bs_resp", 32'(resp_valid_a), 32'h1);

    // Misaligned word load
    set_req(1'b0, SIZE_WORD, 1'b0, 32'h00002001, 32'h0);
    req_valid_a = 1'b1;
    step(); req_valid_a = 1'b0;
    chk("mis_strobes", {30'h0, read_a, write_a}, 32'h0);
    chk("mis_resp", {30'h0, resp_valid_a, resp_error_a}, 32'h3);
    chk("mis_rdata", resp_rdata_a, 32'h0);
    chk("mis_ready", 32'(req_ready_a), 32'h1);
    step();
    chk("mis_pulse", 32'(resp_valid_a), 32'h0);

    // Timeout: waitrequest stuck high, abort after 8 BUS cycles
    set_req(1'b0, SIZE_WORD, 1'b0, 32'h00003000, 32'h0);
    waitrequest = 1'b1;
    req_valid_a = 1'b1;
    step(); req_valid_a = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("to_c%0d_read", i), {31'h0, read_a}, 32'h1);
      chk($sformatf("to_c%0d_resp", i), 32'(resp_valid_a), 32'h0);
      step();
    end
    chk("to_read_drop", 32'(read_a), 32'h0);
    chk("to_resp", {30'h0, resp_valid_a, resp_error_a}, 32'h3);
    chk("to_rdata", resp_rdata_a, 32'h0);
    chk("to_ready", 32'(req_ready_a), 32'h1);
    waitrequest = 1'b0;

    // Reset during RDWAIT on the RD_LATENCY=3 unit
    set_req(1'b0, SIZE_WORD, 1'b0, 32'h00004000, 32'h0);
    readdata = 32'h11223344;
    req_valid_b = 1'b1;
    step(); req_valid_b = 1'b0;
    chk("rb_c1_read", 32'(read_b), 32'h1);
    step(); step();
    reset_b = 1'b1;
    step();
    chk("rb_rst_strobes", {30'h0, read_b, write_b}, 32'h0);
    chk("rb_rst_resp", 32'(resp_valid_b), 32'h0);
    chk("rb_rst_be", 32'(byteenable_b), 32'h0);
    chk("rb_rst_addr", address_b, 32'h0);
    chk("rb_rst_ready", 32'(req_ready_b), 32'h1);
    reset_b = 1'b0;
    step();
    chk("rb_no_resp", 32'(resp_valid_b), 32'h0);

    // Fresh byte load on unit B: resp at cycle 2+3
    set_req(1'b0, SIZE_BYTE, 1'b0, 32'h00004001, 32'h0);
    req_valid_b = 1'b1;
    step(); req_valid_b = 1'b0;
    chk("rb2_be", 32'(byteenable_b), 32'h2);
    step(); step(); step();
    chk("rb2_c4_resp", 32'(resp_valid_b), 32'h0);
    step();
    chk("rb2_c5_resp", 32'(resp_valid_b), 32'h1);
    chk("rb2_rdata", resp_rdata_b, 32'h00000033);
    chk("rb2_err", 32'(resp_error_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mem_unit.md
Name: mips_mem_unit

Overview:
Parametrised Avalon-MM load/store/fetch master that replaces the ad-hoc bus handling inside the CPU top level. It accepts one byte/half/word request at a time from the core over a valid/ready handshake. It drives an aligned Avalon transaction with computed byteenable and lane-replicated writedata, and tolerates waitrequest. It returns a sign- or zero-extended result after a configurable read latency, and flags misalignment and bus timeouts.

Parameters:
ADDR_W, 32, width of req_addr and Avalon address (≥3)
RD_LATENCY, 1, cycles from read accepted (!waitrequest) to readdata valid; legal 1..4
WAIT_TIMEOUT, 0, consecutive waitrequest-high cycles before abort; 0 = never abort

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  core request present
req_ready  out  1  unit idle, can accept request
req_write  in  1  1 = store, 0 = load/fetch
req_size  in  2  mem_size_t: byte/half/word
req_signed  in  1  sign-extend load result (ignored for word/store)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle pulse, response present
resp_rdata  out  32  extended load data; 0 for stores/errors
resp_error  out  1  misaligned or timed out; valid with resp_valid
address  out  ADDR_W  Avalon word-aligned address
read  out  1  Avalon read
write  out  1  Avalon write
waitrequest  in  1  Avalon stall
writedata  out  32  Avalon write data
byteenable  out  4  Avalon lane enables
readdata  in  32  Avalon read data

Behaviour:
- Reset: state IDLE; read=write=0; byteenable=0; address=0; writedata=0; resp_valid=0; resp_rdata=0; resp_error=0; timeout and latency counters 0. Reset mid-transaction aborts immediately with no response; the bus strobes drop the next cycle.
- req_ready = (state==IDLE); accept on req_valid&&req_ready at a clock edge; request fields are registered on acceptance.
- Lane map is little-endian: lane n = addr[1:0]==n, data bits [8n+7:8n].
- Byte: byteenable = 1<<addr[1:0]; writedata = wdata[7:0] replicated x4.
- Half: byteenable = addr[1] ? 4'b1100 : 4'b0011; writedata = wdata[15:0] replicated x2.
- Word: byteenable = 4'b1111; writedata = wdata.
- Misaligned (half with addr[0]=1; word with addr[1:0]!=0): no bus cycle; resp_valid=1, resp_error=1, resp_rdata=0 in the cycle after acceptance; back to IDLE.
- States: IDLE -> BUS -> (write: IDLE with resp pulse | read: RDWAIT -> IDLE with resp pulse); IDLE -> ERR path for misalignment.
- BUS: address = {addr[ADDR_W-1:2],2'b00}; read or write held with stable address/writedata/byteenable until an edge where waitrequest=0. Exactly one strobe is asserted.
- Write accepted: strobes low next cycle, resp_valid pulse in that same cycle, resp_error=0.
- Read accepted: RDWAIT counts RD_LATENCY cycles. readdata is sampled in the last RDWAIT cycle, lane extracted (byte/half at addr[1:0]), extended per req_signed. resp_valid pulse in the following cycle.
- Timeout: if WAIT_TIMEOUT>0 and waitrequest is high for WAIT_TIMEOUT consecutive BUS cycles, drop the strobe (deliberate protocol abort), resp_valid=1, resp_error=1, resp_rdata=0.
- A new request cannot be accepted in a resp_valid cycle if the state is still non-IDLE. Back-to-back: the next acceptance is earliest in the resp_valid cycle (req_ready=1 there).
- Latency, aligned, no waits, accepted cycle 0: write resp cycle 2; read resp cycle 2+RD_LATENCY.
- resp_rdata and resp_error hold their last values when resp_valid=0.

Decomposition:
- Shared package mips_pkg: mem_size_t enum {SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2}; memu_state_t {IDLE, BUS, RDWAIT, RESP}.
- Sub-module mips_lane_align (combinational): size, addr[1:0], wdata, readdata, signed -> byteenable, writedata, extracted/extended load value, misaligned flag.

Test Plan:
- Word load addr 0xBFC00004, readdata 0x8C220010, no waits, RD_LATENCY=1 -> address 0xBFC00004, byteenable 1111, read one cycle, resp_rdata 0x8C220010 in cycle 3, error 0.
- Signed byte load addr 0x1003, readdata 0x80FF0012 -> byteenable 1000, resp_rdata 0xFFFFFF80; same with req_signed=0 -> 0x00000080.
- Half store addr 0x2002, wdata 0x1234ABCD, waitrequest high 3 cycles -> write/address 0x2000/byteenable 1100/writedata 0xABCDABCD held 4 cycles, resp_valid one cycle later, error 0.
- Word load addr 0x2001 -> no read/write asserted, resp_valid+resp_error next cycle, resp_rdata 0.
- WAIT_TIMEOUT=8, waitrequest stuck high -> read drops after 8 BUS cycles, resp_error=1, req_ready returns 1.
- Reset asserted during RDWAIT with RD_LATENCY=3 -> no resp_valid, all outputs at reset values next cycle, a fresh request then completes normally.
